// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: round-robin IF/D arbiter for one shared RAM with read-response routing
module riscv_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int RAM_LAT = 1
) (
    input  logic          clk,
    input  logic          x_reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [3:0]    d_be,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic [3:0]    ram_be,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy
);
    logic               fav_if;
    logic [RAM_LAT-1:0] pv;
    logic [RAM_LAT-1:0] po;
    logic [DW-1:0]      if_rdata_q;
    logic [DW-1:0]      d_rdata_q;
    logic               push_rd;
    // grant: a lone requester wins, contention goes to the favoured side
    always_comb begin
        d_gnt   = d_req && (!if_req || !fav_if);
        if_gnt  = if_req && !d_gnt;
        push_rd = if_gnt || (d_gnt && !d_we);
    end
    // RAM command is driven only in a grant cycle, otherwise all zero
    always_comb begin
        ram_en    = if_gnt || d_gnt;
        ram_we    = d_gnt && d_we;
        ram_addr  = d_gnt ? d_addr : if_gnt ? if_addr : '0;
        ram_wdata = d_gnt ? d_wdata : '0;
        ram_be    = d_gnt ? d_be : if_gnt ? 4'hf : 4'h0;
    end
    // priority pointer and in-flight pipe of {valid, owner}; owner 1 = D
    always_ff @(posedge clk or negedge x_reset) begin
        if (!x_reset) begin
            fav_if <= 1'b0;
            pv     <= '0;
            po     <= '0;
        end else begin
            if (if_gnt || d_gnt) fav_if <= d_gnt;
            pv[0] <= push_rd;
            po[0] <= d_gnt;
            for (int i = 1; i < RAM_LAT; i++) begin
                pv[i] <= pv[i-1];
                po[i] <= po[i-1];
            end
        end
    end
    // retiring entry steers the response; rdata holds its last value between pulses
    always_comb begin
        if_rvalid = pv[RAM_LAT-1] && !po[RAM_LAT-1];
        d_rvalid  = pv[RAM_LAT-1] && po[RAM_LAT-1];
        if_rdata  = if_rvalid ? ram_rdata : if_rdata_q;
        d_rdata   = d_rvalid ? ram_rdata : d_rdata_q;
        busy      = |pv;
    end
    // capture returned read data per owner
    always_ff @(posedge clk or negedge x_reset) begin
        if (!x_reset) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (if_rvalid) if_rdata_q <= ram_rdata;
            if (d_rvalid) d_rdata_q <= ram_rdata;
        end
    end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: checks two arbiter instances (RAM_LAT 1 and 3) against a transaction-level model
module tb_riscv_mem_arbiter;
    typedef struct packed {
        logic        if_gnt;
        logic        if_rvalid;
        logic [31:0] if_rdata;
        logic        d_gnt;
        logic        d_rvalid;
        logic [31:0] d_rdata;
        logic        ram_en;
        logic        ram_we;
        logic [31:0] ram_addr;
        logic [31:0] ram_wdata;
        logic [3:0]  ram_be;
        logic        busy;
    } obs_t;

    logic        clk = 1'b0;
    logic        x_reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_be = '0;
    obs_t        oa;
    obs_t        ob;
    logic [31:0] rd_a;
    logic [31:0] rd_b;

    always #5 clk = ~clk;

    riscv_mem_arbiter #(.AW(32), .DW(32), .RAM_LAT(1)) u_a (
        .clk(clk), .x_reset(x_reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(oa.if_gnt),
        .if_rvalid(oa.if_rvalid), .if_rdata(oa.if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(oa.d_gnt), .d_rvalid(oa.d_rvalid), .d_rdata(oa.d_rdata),
        .ram_en(oa.ram_en), .ram_we(oa.ram_we), .ram_addr(oa.ram_addr),
        .ram_wdata(oa.ram_wdata), .ram_be(oa.ram_be), .ram_rdata(rd_a), .busy(oa.busy)
    );

    riscv_mem_arbiter #(.AW(32), .DW(32), .RAM_LAT(3)) u_b (
        .clk(clk), .x_reset(x_reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(ob.if_gnt),
        .if_rvalid(ob.if_rvalid), .if_rdata(ob.if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(ob.d_gnt), .d_rvalid(ob.d_rvalid), .d_rdata(ob.d_rdata),
        .ram_en(ob.ram_en), .ram_we(ob.ram_we), .ram_addr(ob.ram_addr),
        .ram_wdata(ob.ram_wdata), .ram_be(ob.ram_be), .ram_rdata(rd_b), .busy(ob.busy)
    );

    // RAM macros driven by each DUT's actual commands; non-read slots return noise
    logic [31:0] shadow [1024];
    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [1024];
    logic [31:0] rp_a [1];
    logic [31:0] rp_b [3];
    bit          seeded = 1'b0;

    assign rd_a = rp_a[0];
    assign rd_b = rp_b[2];

    always @(posedge clk) begin
        if (!seeded) begin
            for (int j = 0; j < 1024; j++) mem_a[j] <= shadow[j];
        end else if (oa.ram_en && oa.ram_we) begin
            for (int j = 0; j < 4; j++)
                if (oa.ram_be[j]) mem_a[oa.ram_addr[11:2]][8*j +: 8] <= oa.ram_wdata[8*j +: 8];
        end
        rp_a[0] <= (oa.ram_en && !oa.ram_we) ? mem_a[oa.ram_addr[11:2]] : $urandom;
    end

    always @(posedge clk) begin
        if (!seeded) begin
            for (int j = 0; j < 1024; j++) mem_b[j] <= shadow[j];
        end else if (ob.ram_en && ob.ram_we) begin
            for (int j = 0; j < 4; j++)
                if (ob.ram_be[j]) mem_b[ob.ram_addr[11:2]][8*j +: 8] <= ob.ram_wdata[8*j +: 8];
        end
        rp_b[0] <= (ob.ram_en && !ob.ram_we) ? mem_b[ob.ram_addr[11:2]] : $urandom;
        rp_b[1] <= rp_b[0];
        rp_b[2] <= rp_b[1];
    end

    // reference model: who is favoured, expected responses keyed by (cycle, instance)
    bit          fav_if;
    bit          eg_if;
    bit          eg_d;
    int          cyc;
    int          n_chk;
    int          n_err;
    logic [32:0] ev [int];
    logic [31:0] last_if [2];
    logic [31:0] last_d [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic predict();
        if (if_req && d_req) begin
            eg_d  = !fav_if;
            eg_if = fav_if;
        end else begin
            eg_d  = d_req;
            eg_if = if_req;
        end
    endtask

    task automatic chk_dut(input int k, input int lat, input obs_t o);
        string       p;
        logic [32:0] e;
        bit          hv;
        bit          bz;
        p  = k != 0 ? "L3" : "L1";
        hv = ev.exists(cyc * 2 + k);
        e  = hv ? ev[cyc * 2 + k] : 33'd0;
        if (hv && e[32]) last_d[k] = e[31:0];
        if (hv && !e[32]) last_if[k] = e[31:0];
        bz = 1'b0;
        for (int c = cyc; c < cyc + lat; c++) if (ev.exists(c * 2 + k)) bz = 1'b1;
        chk({p, ".if_gnt"}, 32'(o.if_gnt), 32'(eg_if));
        chk({p, ".d_gnt"}, 32'(o.d_gnt), 32'(eg_d));
        chk({p, ".ram_en"}, 32'(o.ram_en), 32'(eg_if || eg_d));
        chk({p, ".ram_we"}, 32'(o.ram_we), 32'(eg_d && d_we));
        chk({p, ".ram_be"}, 32'(o.ram_be), 32'(eg_if ? 4'hf : eg_d ? d_be : 4'h0));
        if (eg_if || eg_d) chk({p, ".ram_addr"}, o.ram_addr, eg_d ? d_addr : if_addr);
        if (eg_d) chk({p, ".ram_wdata"}, o.ram_wdata, d_wdata);
        chk({p, ".if_rvalid"}, 32'(o.if_rvalid), 32'(hv && !e[32]));
        chk({p, ".d_rvalid"}, 32'(o.d_rvalid), 32'(hv && e[32]));
        chk({p, ".if_rdata"}, o.if_rdata, last_if[k]);
        chk({p, ".d_rdata"}, o.d_rdata, last_d[k]);
        chk({p, ".busy"}, 32'(o.busy), 32'(bz));
    endtask

    task automatic commit();
        logic [31:0] a;
        if (!(eg_if || eg_d)) return;
        a      = eg_d ? d_addr : if_addr;
        fav_if = eg_d;
        if (eg_d && d_we) begin
            for (int j = 0; j < 4; j++)
                if (d_be[j]) shadow[a[11:2]][8*j +: 8] = d_wdata[8*j +: 8];
        end else begin
            ev[(cyc + 1) * 2 + 0] = {eg_d, shadow[a[11:2]]};
            ev[(cyc + 3) * 2 + 1] = {eg_d, shadow[a[11:2]]};
        end
    endtask

    task automatic step();
        @(negedge clk);
        predict();
        chk_dut(0, 1, oa);
        chk_dut(1, 3, ob);
        @(posedge clk);
        if (x_reset) commit();
        cyc++;
        #1;
    endtask

    task automatic clear_model();
        ev.delete();
        fav_if = 1'b0;
        for (int k = 0; k < 2; k++) begin
            last_if[k] = '0;
            last_d[k]  = '0;
        end
    endtask

    task automatic set_d(input logic req, input logic we, input logic [31:0] a,
                         input logic [31:0] w, input logic [3:0] be);
        d_req   = req;
        d_we    = we;
        d_addr  = a;
        d_wdata = w;
        d_be    = be;
    endtask

    function automatic logic [31:0] pick();
        int i;
        i = $urandom_range(0, 67);
        return i < 64 ? 32'(i * 4) : 32'h200 + 32'((i - 64) * 4);
    endfunction

    initial begin
        for (int j = 0; j < 1024; j++) shadow[j] = (j < 65) ? $urandom : 32'd0;
        clear_model();
        step();
        seeded = 1'b1;
        step();
        x_reset = 1'b1;
        step();
        // IF alone fetches three consecutive words
        if_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_addr = 32'(i * 4);
            step();
        end
        if_req = 1'b0;
        repeat (4) step();
        // contention: D read 0x100 and IF held together, grants alternate from D
        if_req = 1'b1;
        if_addr = 32'h0c;
        set_d(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        repeat (4) step();
        if_req = 1'b0;
        set_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (4) step();
        // partial write then read back over a zero word
        set_d(1'b1, 1'b1, 32'h200, 32'hdeadbeef, 4'b0011);
        step();
        set_d(1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
        step();
        set_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (4) step();
        // four alternating reads back to back
        if_req = 1'b1;
        if_addr = 32'h20;
        set_d(1'b1, 1'b0, 32'h24, 32'h0, 4'h0);
        step();
        step();
        if_addr = 32'h28;
        d_addr = 32'h2c;
        step();
        step();
        if_req = 1'b0;
        set_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (4) step();
        // reset pulse with two reads still in flight on the deep-latency instance
        if_req = 1'b1;
        if_addr = 32'h30;
        set_d(1'b1, 1'b0, 32'h34, 32'h0, 4'h0);
        step();
        step();
        if_req = 1'b0;
        set_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        x_reset = 1'b0;
        #1;
        chk("rst.L3.busy", 32'(ob.busy), 32'd0);
        chk("rst.L3.if_rvalid", 32'(ob.if_rvalid), 32'd0);
        chk("rst.L3.d_rvalid", 32'(ob.d_rvalid), 32'd0);
        chk("rst.L1.if_rvalid", 32'(oa.if_rvalid), 32'd0);
        chk("rst.L1.busy", 32'(oa.busy), 32'd0);
        clear_model();
        step();
        x_reset = 1'b1;
        repeat (5) step();
        if_req = 1'b1;
        if_addr = 32'h38;
        set_d(1'b1, 1'b0, 32'h3c, 32'h0, 4'h0);
        step();
        step();
        if_req = 1'b0;
        set_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        // idle stretch
        repeat (10) step();
        // random traffic; a request is held until the model says it was granted
        for (int n = 0; n < 400; n++) begin
            if (!if_req || eg_if) begin
                if_req  = 1'($urandom_range(0, 1));
                if_addr = pick();
            end
            if (!d_req || eg_d)
                set_d(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), pick(),
                      $urandom, 4'($urandom_range(0, 15)));
            step();
        end
        if_req = 1'b0;
        set_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (5) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Shares the single unified RAM between two requesters: instruction fetch (IF) and load/store data (D).
- Issues at most one RAM command per cycle.
- Arbitrates conflicts round-robin and tracks in-flight reads over a fixed RAM read latency, so each read response returns to the requester that issued it.
- Sits between the PC/fetch logic, the load/store path and the RAM macro. It is the prerequisite for a multi-cycle or stalling core.

Parameters:
- AW, 32, address width.
- DW, 32, data width; must be 32.
- RAM_LAT, 1, cycles from a RAM command cycle to valid ram_rdata; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- x_reset  in  1  asynchronous active-low reset.
- if_req  in  1  IF read request; held with if_addr until granted.
- if_addr  in  AW  IF word address.
- if_gnt  out  1  IF request accepted this cycle.
- if_rvalid  out  1  IF read data valid.
- if_rdata  out  DW  IF read data.
- d_req  in  1  D request; held with its fields until granted.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  D address.
- d_wdata  in  DW  D write data.
- d_be  in  4  D byte enables for writes.
- d_gnt  out  1  D request accepted this cycle.
- d_rvalid  out  1  D read data valid.
- d_rdata  out  DW  D read data.
- ram_en  out  1  RAM command valid.
- ram_we  out  1  RAM write strobe.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  DW  RAM write data.
- ram_be  out  4  RAM byte enables.
- ram_rdata  in  DW  RAM read data, valid RAM_LAT cycles after a read command.
- busy  out  1  one or more reads in flight.

Behaviour:
- Clock and reset: single clock domain (clk). x_reset low asynchronously clears all state.
- Reset values:
  - Registered state is cleared: in-flight pipe empty, busy=0, if_rvalid=0, d_rvalid=0, if_rdata=0, d_rdata=0, priority pointer = "D favoured".
  - Command outputs ram_en, ram_we, ram_be, ram_addr, ram_wdata are combinational. They are 0 because they are gated by the requests; a requester must not assert a request while x_reset is low.
- Grant (combinational, same cycle as the request):
  - Only one requester active: it is granted.
  - Both active: the favoured one is granted.
  - Pointer update on a grant: pointer := favour the other requester. With no grant the pointer holds.
  - At most one of if_gnt/d_gnt is high in any cycle.
- RAM command, cycle of grant:
  - ram_en=1; ram_addr is the granted address.
  - IF grant: ram_we=0, ram_be=4'hF.
  - D grant: ram_we=d_we, ram_be=d_be, ram_wdata=d_wdata.
  - No grant: ram_en=0, ram_we=0, ram_be=0.
- Read tracking:
  - RAM_LAT-deep shift register of {valid, owner}; each granted read pushes {1, IF|D}.
  - When an entry exits at depth RAM_LAT, the owner's rvalid pulses for exactly one cycle, with its rdata = ram_rdata registered zero-latency (combinational pass-through is acceptable only when the registered rdata holds its last value otherwise).
  - Writes push {0, x} and produce no rvalid. A write is complete at grant.
- Latency and ordering:
  - Read response appears RAM_LAT cycles after the grant cycle.
  - Back-to-back grants give back-to-back responses, in issue order.
  - Throughput: 1 command/cycle.
- busy: high while any valid read entry is in the pipe.
- Simultaneous events: a new grant and a response retiring in the same cycle are both legal; the pipe shifts and pushes in one step.
- Fairness: under continuous contention, grants alternate D, IF, D, IF...; neither side waits more than 1 cycle.
- Reset mid-operation: in-flight reads are discarded; no rvalid is produced for them after reset deassertion.
- No back-pressure on responses: each requester must accept rvalid on the cycle it appears.

Test Plan:
- Reset, then IF only: if_req=1 with addr 0x00, 0x04, 0x08 on consecutive cycles, RAM_LAT=1 → if_gnt high 3 cycles; if_rvalid high 3 cycles starting 1 cycle after the first grant, with data matching the RAM model; d_rvalid never high.
- Contention: if_req and d_req (read 0x100) held high from the first cycle after reset → grant order D, IF, D, IF; pointer alternates; each response is routed to the correct owner.
- Write then read: D writes 0xDEADBEEF, be=4'b0011, to 0x200; then D reads 0x200 → ram_we=1 only on the write cycle; no d_rvalid for the write; the read returns 0x0000BEEF over an initially zero RAM.
- RAM_LAT=3, four alternating reads issued back to back → busy high from the first grant until the last response; responses arrive at grant+3, in order, to the correct owners.
- x_reset pulsed low while 2 reads are in flight (RAM_LAT=3) → busy=0 and both rvalids 0 immediately; no rvalid pulses after release; pointer favours D.
- Idle: no requests for 10 cycles → ram_en=0, ram_we=0, ram_be=0 throughout; pointer unchanged.
